ps2_host_tx: RTL and testbench

PS/2 host-to-device transmitter, the sending counterpart to the existing PS/2 receive path. It lets the board send command bytes to the keyboard, such as LED control 8'hED or reset 8'hFF.
- Owns the open-drain drive of PS2_CLOCK and PS2_DATA: it inhibits the bus, issues the request-to-send, and shifts out 8 data bits, odd parity and stop.
- Checks the device acknowledge and reports done or error.
- While TX_busy is high, top level gates PS2_code_ready handling in the receiver.

---
 rtl/ps2_host_tx.sv | 188 ++++++++++++++++++
 tb/tb_ps2_host_tx.sv | 282 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device transmitter: inhibits the bus, issues request-to-send,
// shifts a byte out on device clock falls and checks the device acknowledge.
//
// state       | meaning
// S_IDLE      | lines released, waiting for TX_start
// S_INHIBIT   | clock held low for INHIBIT_CYCLES
// S_REQ       | clock and data held low (start bit) for REQ_CYCLES
// S_SEND      | clock released, data bits / parity / stop driven on device falls
// S_ACK       | waiting for the acknowledge fall, data must be low
// S_WAIT_IDLE | waiting for device to release both lines
module ps2_host_tx #(
   parameter int INHIBIT_CYCLES = 6000,
   parameter int REQ_CYCLES     = 100,
   parameter int TIMEOUT_CYCLES = 1000000
) (
   input  logic       Clock_50,
   input  logic       Resetn,
   input  logic [7:0] TX_data,
   input  logic       TX_start,
   input  logic       PS2_clock_I,
   input  logic       PS2_data_I,
   output logic       PS2_clock_oe,
   output logic       PS2_data_oe,
   output logic       TX_busy,
   output logic       TX_done,
   output logic       TX_error
);

   localparam int MAX_AB     = (INHIBIT_CYCLES > REQ_CYCLES) ? INHIBIT_CYCLES : REQ_CYCLES;
   localparam int MAX_CYCLES = (MAX_AB > TIMEOUT_CYCLES) ? MAX_AB : TIMEOUT_CYCLES;
   localparam int TW         = $clog2(MAX_CYCLES) + 1;

   localparam logic [TW-1:0] INH_LAST = TW'(INHIBIT_CYCLES - 1);
   localparam logic [TW-1:0] REQ_LAST = TW'(REQ_CYCLES - 1);
   localparam logic [TW-1:0] TO_LAST  = TW'(TIMEOUT_CYCLES - 1);

   typedef enum logic [2:0] {
      S_IDLE, S_INHIBIT, S_REQ, S_SEND, S_ACK, S_WAIT_IDLE
   } state_t;

   state_t        state, state_nxt;
   logic [TW-1:0] timer, timer_nxt;
   logic [3:0]    bit_idx, bit_idx_nxt;
   logic [7:0]    shift, shift_nxt;
   logic          parity, parity_nxt;
   logic          clock_oe_nxt, data_oe_nxt, busy_nxt, done_nxt, error_nxt;

   logic clk_meta, clk_sync, clk_prev, data_meta, data_sync;
   logic fall, timeout;

   // Synchronisers idle high so reset release never looks like a falling edge
   always_ff @(posedge Clock_50 or negedge Resetn) begin
      if (!Resetn) begin
         clk_meta  <= 1'b1;
         clk_sync  <= 1'b1;
         clk_prev  <= 1'b1;
         data_meta <= 1'b1;
         data_sync <= 1'b1;
      end else begin
         clk_meta  <= PS2_clock_I;
         clk_sync  <= clk_meta;
         clk_prev  <= clk_sync;
         data_meta <= PS2_data_I;
         data_sync <= data_meta;
      end
   end

   assign fall    = clk_prev & ~clk_sync;
   assign timeout = (timer == TO_LAST);

   always_ff @(posedge Clock_50 or negedge Resetn) begin
      if (!Resetn) begin
         state        <= S_IDLE;
         timer        <= '0;
         bit_idx      <= '0;
         shift        <= '0;
         parity       <= 1'b0;
         PS2_clock_oe <= 1'b0;
         PS2_data_oe  <= 1'b0;
         TX_busy      <= 1'b0;
         TX_done      <= 1'b0;
         TX_error     <= 1'b0;
      end else begin
         state        <= state_nxt;
         timer        <= timer_nxt;
         bit_idx      <= bit_idx_nxt;
         shift        <= shift_nxt;
         parity       <= parity_nxt;
         PS2_clock_oe <= clock_oe_nxt;
         PS2_data_oe  <= data_oe_nxt;
         TX_busy      <= busy_nxt;
         TX_done      <= done_nxt;
         TX_error     <= error_nxt;
      end
   end

   always_comb begin
      state_nxt    = state;
      timer_nxt    = timer + TW'(1);
      bit_idx_nxt  = bit_idx;
      shift_nxt    = shift;
      parity_nxt   = parity;
      clock_oe_nxt = PS2_clock_oe;
      data_oe_nxt  = PS2_data_oe;
      busy_nxt     = TX_busy;
      done_nxt     = 1'b0;
      error_nxt    = 1'b0;

      // Falls only restart the timer once the device owns the clock; our own
      // inhibit edge must not disturb the inhibit/request timing.
      if (fall && (state == S_SEND || state == S_ACK || state == S_WAIT_IDLE))
         timer_nxt = '0;

      case (state)
         S_IDLE: begin
            timer_nxt    = '0;
            clock_oe_nxt = 1'b0;
            data_oe_nxt  = 1'b0;
            busy_nxt     = 1'b0;
            if (TX_start && !TX_done && !TX_error) begin
               shift_nxt    = TX_data;
               parity_nxt   = ~^TX_data;
               bit_idx_nxt  = '0;
               clock_oe_nxt = 1'b1;
               busy_nxt     = 1'b1;
               state_nxt    = S_INHIBIT;
            end
         end
         S_INHIBIT: begin
            if (timer == INH_LAST) begin
               timer_nxt   = '0;
               data_oe_nxt = 1'b1;
               state_nxt   = S_REQ;
            end
         end
         S_REQ: begin
            if (timer == REQ_LAST) begin
               timer_nxt    = '0;
               clock_oe_nxt = 1'b0;
               state_nxt    = S_SEND;
            end
         end
         S_SEND: begin
            if (fall) begin
               bit_idx_nxt = bit_idx + 4'd1;
               if (bit_idx < 4'd8)
                  data_oe_nxt = ~shift[bit_idx[2:0]];
               else if (bit_idx == 4'd8)
                  data_oe_nxt = ~parity;
               else begin
                  data_oe_nxt = 1'b0;
                  state_nxt   = S_ACK;
               end
            end
         end
         S_ACK: begin
            if (fall) begin
               if (!data_sync)
                  state_nxt = S_WAIT_IDLE;
               else begin
                  error_nxt = 1'b1;
                  busy_nxt  = 1'b0;
                  state_nxt = S_IDLE;
               end
            end
         end
         S_WAIT_IDLE: begin
            if (clk_sync && data_sync) begin
               done_nxt  = 1'b1;
               busy_nxt  = 1'b0;
               state_nxt = S_IDLE;
            end
         end
         default: state_nxt = S_IDLE;
      endcase

      // Timeout overrides whatever the device-driven states decided
      if (timeout && (state == S_SEND || state == S_ACK || state == S_WAIT_IDLE)) begin
         clock_oe_nxt = 1'b0;
         data_oe_nxt  = 1'b0;
         busy_nxt     = 1'b0;
         done_nxt     = 1'b0;
         error_nxt    = 1'b1;
         state_nxt    = S_IDLE;
      end
   end

endmodule

// File: tb/tb_ps2_host_tx.sv
// Bench for ps2_host_tx: open-drain bus with a PS/2 device model, a per-cycle
// timeline checker and directed transfers with hand-computed frames.
`timescale 1ns/1ps
module tb_ps2_host_tx;

   localparam int INH  = 60;
   localparam int REQ  = 10;
   localparam int TO   = 2000;
   localparam int HALF = 20;

   logic       Clock_50 = 1'b0;
   logic       Resetn   = 1'b0;
   logic [7:0] TX_data  = 8'h00;
   logic       TX_start = 1'b0;
   logic       dev_clk  = 1'b1;
   logic       dev_data = 1'b1;
   logic       PS2_clock_oe, PS2_data_oe, TX_busy, TX_done, TX_error;
   logic       ps2c, ps2d;

   assign ps2c = ~PS2_clock_oe & dev_clk;
   assign ps2d = ~PS2_data_oe & dev_data;

   ps2_host_tx #(.INHIBIT_CYCLES(INH), .REQ_CYCLES(REQ), .TIMEOUT_CYCLES(TO)) dut (
      .Clock_50     (Clock_50),
      .Resetn       (Resetn),
      .TX_data      (TX_data),
      .TX_start     (TX_start),
      .PS2_clock_I  (ps2c),
      .PS2_data_I   (ps2d),
      .PS2_clock_oe (PS2_clock_oe),
      .PS2_data_oe  (PS2_data_oe),
      .TX_busy      (TX_busy),
      .TX_done      (TX_done),
      .TX_error     (TX_error)
   );

   always #10 Clock_50 = ~Clock_50;

   int n_cmp = 0;
   int n_bad = 0;
   int n_done = 0;
   int n_err = 0;

   // 0 device acks, 1 device withholds ack, 2 device silent, 3 reset aborts
   int   m_mode = 0;
   logic m_active = 1'b0;
   int   m_since = 0;
   logic dev_fall11 = 1'b0;
   logic dev_released = 1'b0;
   int   dev_falls = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Frame as the device sees it: 8 data bits LSB first, odd parity, stop
   function automatic logic [9:0] frame_of(input logic [7:0] d);
      int ones;
      ones = 0;
      for (int i = 0; i < 8; i++) ones += int'(d[i]);
      return {1'b1, (ones % 2 == 0), d};
   endfunction

   logic [4:0] c_act, c_exp, c_mask;
   logic       c_pulse, c_ended;

   // Timeline checker: {busy, clock_oe, data_oe, done, error} every cycle
   always @(negedge Clock_50) begin
      if (!Resetn) begin
         m_active = 1'b0;
         m_since  = 0;
      end else begin
         c_act   = {TX_busy, PS2_clock_oe, PS2_data_oe, TX_done, TX_error};
         c_pulse = TX_done | TX_error;
         c_mask  = 5'b11111;
         c_exp   = 5'b00000;
         if (m_active) begin
            if (m_since <= INH)
               c_exp = 5'b11000;
            else if (m_since <= INH + REQ)
               c_exp = 5'b11100;
            else if (m_mode == 2) begin
               if (m_since == INH + REQ + 1 + TO) c_exp = 5'b00001;
               else begin c_exp = 5'b10000; c_mask = 5'b11011; end
            end else if (c_pulse && ((m_mode == 0 && dev_released) || (m_mode == 1 && dev_fall11)))
               c_exp = (m_mode == 0) ? 5'b00010 : 5'b00001;
            else begin
               c_exp  = 5'b10000;
               c_mask = 5'b11011;
            end
         end
         check("cycle", 32'(c_act & c_mask), 32'(c_exp));
         c_ended = m_active && (m_since > INH + REQ) && ((c_exp & 5'b00011) != 5'b0);
         if (c_ended)
            m_active = 1'b0;
         else if (m_active)
            m_since++;
         else if (TX_start) begin
            m_active = 1'b1;
            m_since  = 1;
         end
      end
   end

   always @(negedge Clock_50) begin
      if (Resetn) begin
         if (TX_done)  n_done++;
         if (TX_error) n_err++;
      end
   end

   task automatic dev_transfer(input logic ack, output logic [9:0] bits);
      int w;
      bits = '0;
      w = 0;
      while (!(ps2c && !ps2d) && w < 5000) begin
         @(negedge Clock_50);
         w++;
      end
      check("rts_seen", 32'(ps2c && !ps2d), 32'd1);
      if (w >= 5000) return;
      repeat (10) @(negedge Clock_50);
      for (int i = 0; i < 11; i++) begin
         dev_clk = 1'b0;
         dev_falls++;
         if (i == 10) dev_fall11 = 1'b1;
         repeat (HALF) @(negedge Clock_50);
         if (i < 10) bits[i] = ps2d;
         dev_clk = 1'b1;
         if (i == 10) begin
            dev_data     = 1'b1;
            dev_released = 1'b1;
         end
         if (i == 9 && ack) dev_data = 1'b0;
         repeat (HALF) @(negedge Clock_50);
      end
   endtask

   task automatic clear_dev();
      dev_fall11   = 1'b0;
      dev_released = 1'b0;
      dev_falls    = 0;
   endtask

   task automatic pulse_start(input logic [7:0] d);
      @(posedge Clock_50); #1;
      TX_data  = d;
      TX_start = 1'b1;
      @(posedge Clock_50); #1;
      TX_start = 1'b0;
   endtask

   task automatic send(input logic [7:0] d, input logic ack, output logic [9:0] bits);
      clear_dev();
      m_mode = ack ? 0 : 1;
      pulse_start(d);
      dev_transfer(ack, bits);
   endtask

   logic [9:0] bits, bits2;
   int d0, e0, w;

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      repeat (4) @(posedge Clock_50);
      #1;
      check("reset_outs", 32'({PS2_clock_oe, PS2_data_oe, TX_busy, TX_done, TX_error}), 32'd0);
      Resetn = 1'b1;
      repeat (5) @(posedge Clock_50);

      // LED command with ack
      d0 = n_done; e0 = n_err;
      send(8'hED, 1'b1, bits);
      check("ed_frame_model", 32'(bits), 32'(frame_of(8'hED)));
      check("ed_frame_lit", 32'(bits), 32'h3ED);
      check("ed_done", n_done - d0, 1);
      check("ed_err", n_err - e0, 0);
      check("ed_busy_after", 32'(TX_busy), 32'd0);

      d0 = n_done;
      send(8'hF4, 1'b1, bits);
      check("f4_frame_lit", 32'(bits), 32'h2F4);
      check("f4_frame_model", 32'(bits), 32'(frame_of(8'hF4)));
      send(8'h00, 1'b1, bits);
      check("00_frame_lit", 32'(bits), 32'h300);
      check("f4_00_done", n_done - d0, 2);

      // Missing acknowledge
      d0 = n_done; e0 = n_err;
      send(8'hA5, 1'b0, bits);
      check("nack_frame", 32'(bits), 32'(frame_of(8'hA5)));
      check("nack_err", n_err - e0, 1);
      check("nack_done", n_done - d0, 0);
      check("nack_oe", 32'({PS2_clock_oe, PS2_data_oe}), 32'd0);

      // Silent device: error exactly TO cycles after clock release
      clear_dev();
      m_mode = 2;
      d0 = n_done; e0 = n_err;
      pulse_start(8'h12);
      w = 0;
      while (ps2c && w < 200) begin @(negedge Clock_50); w++; end
      while (!ps2c && w < 400) begin @(negedge Clock_50); w++; end
      w = 0;
      while (!TX_error && w < TO + 100) begin @(negedge Clock_50); w++; end
      check("timeout_cycles", w, TO);
      check("timeout_oe", 32'({PS2_clock_oe, PS2_data_oe}), 32'd0);
      repeat (3) @(negedge Clock_50);
      check("timeout_err", n_err - e0, 1);
      check("timeout_done", n_done - d0, 0);

      // Start while busy is ignored; start during done pulse is deferred a cycle
      clear_dev();
      m_mode = 0;
      d0 = n_done;
      pulse_start(8'hED);
      fork
         dev_transfer(1'b1, bits);
         begin
            w = 0;
            while (dev_falls < 3 && w < 2000) begin @(negedge Clock_50); w++; end
            pulse_start(8'h55);
            w = 0;
            @(posedge Clock_50); #1;
            while (!TX_done && w < 2000) begin @(posedge Clock_50); #1; w++; end
            check("mid_done_seen", 32'(TX_done), 32'd1);
            TX_data  = 8'hF4;
            TX_start = 1'b1;
            @(posedge Clock_50); #1;
            check("start_in_pulse_ignored", 32'(TX_busy), 32'd0);
            @(posedge Clock_50); #1;
            TX_start = 1'b0;
            check("start_after_pulse", 32'(TX_busy), 32'd1);
         end
      join
      check("mid_frame_lit", 32'(bits), 32'h3ED);
      check("mid_single_done", n_done - d0, 1);
      clear_dev();
      dev_transfer(1'b1, bits2);
      check("deferred_frame", 32'(bits2), 32'h2F4);
      check("deferred_done", n_done - d0, 2);

      // Reset during bit 4 of 8'hED
      clear_dev();
      m_mode = 3;
      d0 = n_done; e0 = n_err;
      pulse_start(8'hED);
      fork
         dev_transfer(1'b1, bits);
         begin
            w = 0;
            while (dev_falls < 5 && w < 2000) begin @(negedge Clock_50); w++; end
            repeat (5) @(negedge Clock_50);
            check("bit4_driven", 32'({PS2_data_oe, TX_busy}), 32'b11);
            #3 Resetn = 1'b0;
            #1 check("reset_release", 32'({PS2_clock_oe, PS2_data_oe, TX_busy, TX_done, TX_error}), 32'd0);
         end
      join
      @(posedge Clock_50); #3;
      Resetn = 1'b1;
      repeat (3) @(posedge Clock_50);
      check("reset_no_pulse", (n_done - d0) + (n_err - e0), 0);
      m_mode = 0;
      send(8'h00, 1'b1, bits);
      check("post_reset_frame", 32'(bits), 32'h300);
      check("post_reset_done", n_done - d0, 1);
      repeat (5) @(negedge Clock_50);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
